// File: rtl/dot_accumulator_pkg.sv
// Shared NPU definitions: datapath widths, accumulator saturation bounds and
// the dot-product FSM state type.
`ifndef NPU_DATA_WIDTH
`define NPU_DATA_WIDTH 8
`endif
`ifndef NPU_ACC_WIDTH
`define NPU_ACC_WIDTH 20
`endif

package dot_accumulator_pkg;

    localparam int DATA_WIDTH = `NPU_DATA_WIDTH;
    localparam int ACC_WIDTH  = `NPU_ACC_WIDTH;
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FLUSH  = 2'd2,
        OUTPUT = 2'd3
    } dot_state_t;

endpackage

// File: rtl/dot_accumulator_sat.sv
// Signed saturating ACC_WIDTH adder; overflow flags that the sum was clamped.
module sat_adder
    import dot_accumulator_pkg::*;
(
    input  logic signed [ACC_WIDTH-1:0] a,
    input  logic signed [ACC_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0] sum,
    output logic                        overflow
);

    logic signed [ACC_WIDTH:0] wide;

    // One guard bit: overflow shows up as the top two bits disagreeing.
    always_comb begin
        wide     = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        overflow = (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]);
        if (!overflow)
            sum = wide[ACC_WIDTH-1:0];
        else if (wide[ACC_WIDTH])
            sum = ACC_MIN;
        else
            sum = ACC_MAX;
    end

endmodule

// File: rtl/dot_accumulator.sv
// Streaming signed dot-product engine: multiplies beat pairs, accumulates with
// saturation one cycle later, and hands the sum to the quantizer.
module dot_accumulator
    import dot_accumulator_pkg::*;
#(
    parameter int LEN_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [LEN_WIDTH-1:0]         len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] a_data,
    input  logic signed [DATA_WIDTH-1:0] b_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_WIDTH-1:0]  out_data,
    output logic                         sat,
    output logic                         busy
);

    dot_state_t                   state;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [PROD_WIDTH-1:0] prod;
    logic                         prod_valid;
    logic [LEN_WIDTH-1:0]         count;

    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic                         overflow;
    logic                         beat;

    assign prod_ext = ACC_WIDTH'(prod);
    assign beat     = in_valid && (state == ACCUM);

    sat_adder u_sat_adder (
        .a        (acc),
        .b        (prod_ext),
        .sum      (sum),
        .overflow (overflow)
    );

    // prod_valid marks a product waiting to be added, so stalls add nothing
    // while back-to-back beats overlap multiply and accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            prod       <= '0;
            prod_valid <= 1'b0;
            count      <= '0;
            sat        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc        <= '0;
                        sat        <= 1'b0;
                        prod_valid <= 1'b0;
                        if (len != '0) begin
                            count <= len;
                            prod  <= '0;
                            state <= ACCUM;
                        end else begin
                            state <= OUTPUT;
                        end
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc <= sum;
                        sat <= sat | overflow;
                    end
                    prod_valid <= beat;
                    if (beat) begin
                        prod  <= PROD_WIDTH'(a_data) * PROD_WIDTH'(b_data);
                        count <= count - 1'b1;
                        if (count == LEN_WIDTH'(1))
                            state <= FLUSH;
                    end
                end
                FLUSH: begin
                    acc        <= sum;
                    sat        <= sat | overflow;
                    prod_valid <= 1'b0;
                    state      <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUTPUT);
    assign busy      = (state != IDLE);
    assign out_data  = acc;

endmodule

// File: doc/dot_accumulator.md
DOT_ACCUMULATOR -- requirements
Module: dot_accumulator

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 8: width of the vector-length field.
REQ-002 SHALL take widths DATA_WIDTH and ACC_WIDTH from the shared width macros; 2*DATA_WIDTH <= ACC_WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin a new dot product; sampled only in IDLE.
REQ-006 len  input  LEN_WIDTH  unsigned beat count, captured with start.
REQ-007 in_valid  input  1  a_data/b_data valid.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 a_data, b_data  input  DATA_WIDTH each  signed operands.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream (quantizer) accepts result.
REQ-012 out_data  output  ACC_WIDTH  signed accumulated sum, feeds the quantizer input.
REQ-013 sat  output  1  result was clamped during this dot product.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM SHALL have states IDLE, ACCUM, FLUSH, OUTPUT.
REQ-016 IDLE: start=1 and len>0 -> capture len, clear accumulator, product register and sat -> ACCUM; start=1 and len=0 -> clear accumulator and sat -> OUTPUT.
REQ-017 start SHALL be ignored in every state other than IDLE.
REQ-018 in_ready SHALL be 1 only in ACCUM; a beat is accepted on an edge where in_valid && in_ready.
REQ-019 Each accepted beat: product register <= a_data*b_data (full signed 2*DATA_WIDTH precision); remaining count decrements by 1.
REQ-020 Accumulator SHALL add the sign-extended product register one cycle after each beat is accepted.
REQ-021 On acceptance of the final beat (remaining count = 1), FSM SHALL go ACCUM -> FLUSH; FLUSH adds the last product and goes to OUTPUT unconditionally.
REQ-022 Latency: out_valid SHALL rise 2 cycles after the edge that accepts the final beat.
REQ-023 Stalls: in_valid=0 in ACCUM SHALL hold count and accumulator and add nothing; no bubble penalty beyond the stall itself.
REQ-024 Addition SHALL saturate to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; any clamp sets sat, which stays set until the next start.
REQ-025 After saturation, later additions SHALL continue from the clamped value (not from a wrapped value).
REQ-026 OUTPUT: out_valid=1; out_data and sat SHALL stay stable while out_valid && !out_ready.
REQ-027 OUTPUT with out_ready=1 -> IDLE on that edge; out_valid=0 on the next cycle.
REQ-028 start asserted in the same cycle as the OUTPUT handshake SHALL be ignored (FSM is in OUTPUT, not IDLE).
REQ-029 out_data SHALL equal the accumulator in all states; it is meaningful only while out_valid=1.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, accumulator=0, product register=0, count=0, sat=0, so in_ready=0, out_valid=0, busy=0, out_data=0.
REQ-031 Reset during ACCUM/FLUSH/OUTPUT SHALL discard the partial result; no out_valid follows.

Structure
REQ-032 FSM state enum typedef SHALL live in the shared NPU package beside the width definitions; saturation bounds SHALL be derived from ACC_WIDTH there as constants.
REQ-033 Single module; one sub-module is natural: sat_adder (signed saturating ACC_WIDTH add with overflow flag), reusable elsewhere.

Verification
REQ-034 start, len=3, beats (2,3),(-4,5),(7,7) back to back, out_ready=1 -> out_data=35, sat=0, out_valid 2 cycles after third accept, single cycle.
REQ-035 start, len=0 -> out_valid=1 with out_data=0 on the cycle after start; in_ready never asserts.
REQ-036 len=4, operands at signed max (e.g. 127*127 for DATA_WIDTH=8), in_valid gapped every other cycle, out_ready held 0 for 5 cycles -> out_data=64516, stable for all held cycles, in_ready low outside ACCUM.
REQ-037 Accumulator driven past 2^(ACC_WIDTH-1)-1 (narrow ACC_WIDTH build or long max-product stream), then one negative product -> sat=1, out_data = max minus that product's magnitude.
REQ-038 rst pulsed mid-ACCUM after 2 of 5 beats -> all outputs 0 immediately; following start, len=1, (3,-3) -> out_data=-9, sat=0.
REQ-039 start held high through OUTPUT handshake -> exactly one new dot product begins, from the IDLE cycle after the handshake.
